// File: rtl/muldiv_sequencer.sv
// Sequential multiply/divide unit. One radix-2 iteration per clock: shift-and-add
// for MULT/MULTU, restoring shift-subtract for DIV/DIVU. Both run on magnitudes,
// and the signs are restored in a final fixup cycle. HI/LO hold the last result.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [5:0]       count
);

  localparam logic [5:0] LastIter = 6'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           opReg_q, opReg_d;
  logic                 signA_q, signA_d;
  logic                 signB_q, signB_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]     operand_q, operand_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dbz_q, dbz_d;
  logic [5:0]           count_q, count_d;

  logic                 rsNeg, rtNeg;
  logic [WIDTH-1:0]     rsMag, rtMag;
  logic [WIDTH:0]       mulSum;
  logic [2*WIDTH-1:0]   mulNext;
  logic [WIDTH:0]       remShift;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   divNext;

  assign busy        = (state_q == CALC) || (state_q == FIXUP);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign count       = count_q;

  // Operand magnitude and sign extraction, and one iteration step for each datapath
  always_comb begin
    rsNeg    = ~op[0] & rs_val[WIDTH-1];
    rtNeg    = ~op[0] & rt_val[WIDTH-1];
    rsMag    = rsNeg ? -rs_val : rs_val;
    rtMag    = rtNeg ? -rt_val : rt_val;
    mulSum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, operand_q};
    mulNext  = work_q[0] ? {mulSum, work_q[WIDTH-1:1]} : {1'b0, work_q[2*WIDTH-1:1]};
    remShift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    diff     = remShift - {1'b0, operand_q};
    divNext  = diff[WIDTH] ? {remShift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
  end

  // Next-state logic: accept in IDLE/DONE, iterate in CALC, sign-correct and commit in FIXUP
  always_comb begin
    state_d   = state_q;
    opReg_d   = opReg_q;
    signA_d   = signA_q;
    signB_d   = signB_q;
    work_d    = work_q;
    operand_d = operand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    count_d   = count_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
          count_d = '0;
        end
        if (start) begin
          opReg_d = op;
          signA_d = rsNeg;
          signB_d = rtNeg;
          count_d = '0;
          dbz_d   = 1'b0;
          if (op[1] && (rt_val == '0)) begin
            dbz_d   = 1'b1;
            hi_d    = rs_val;
            lo_d    = '1;
            work_d  = '0;
            state_d = DONE;
          end else if (op[1]) begin
            work_d    = {{WIDTH{1'b0}}, rsMag};
            operand_d = rtMag;
            state_d   = CALC;
          end else begin
            work_d    = {{WIDTH{1'b0}}, rtMag};
            operand_d = rsMag;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        work_d  = opReg_q[1] ? divNext : mulNext;
        count_d = count_q + 6'd1;
        if (count_q + 6'd1 == LastIter) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        if (opReg_q[1]) begin
          lo_d = (signA_q ^ signB_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
          hi_d = signA_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = (signA_q ^ signB_q) ? -work_q : work_q;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously so an abort never commits
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      opReg_q   <= '0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      work_q    <= '0;
      operand_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      opReg_q   <= opReg_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      work_q    <= work_d;
      operand_q <= operand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with hand-computed expected results.
module tb_muldiv_sequencer;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rsVal = '0;
  logic [31:0] rtVal = '0;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;
  logic [5:0]  count;

  int checks = 0;
  int errors = 0;
  int busyCycles, edges;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op),
    .rs_val(rsVal), .rt_val(rtVal), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(divByZero), .count(count)
  );

  // Free-running clock, period 10
  always #5 Clk = ~Clk;

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    start = 1'b1; op = o; rsVal = a; rtVal = b;
    @(posedge Clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(output int busyCnt, output int edgeCnt);
    busyCnt = 0;
    edgeCnt = 0;
    while (edgeCnt < 100) begin
      @(negedge Clk);
      edgeCnt++;
      if (done) break;
      if (busy) busyCnt++;
    end
    if (!done) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitCount(input logic [5:0] target);
    int n;
    n = 0;
    while (count != target && n < 60) begin
      @(negedge Clk);
      n++;
    end
    if (count != target) checkOutput("count_timeout", {58'd0, count}, {58'd0, target});
  endtask

  initial begin
    $display("[TB] starting muldiv_sequencer bench");
    #1 reset = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    checkOutput("reset_dbz", {63'd0, divByZero}, 64'd0);
    checkOutput("reset_count", {58'd0, count}, 64'd0);
    reset = 1'b1;

    // MULTU max x max, with latency checks
    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(busyCycles, edges);
    checkOutput("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    checkOutput("multu_busy_cycles", 64'(busyCycles), 64'd33);
    checkOutput("multu_done_edge", 64'(edges), 64'd34);
    checkOutput("multu_count_done", {58'd0, count}, 64'd32);
    @(negedge Clk);
    checkOutput("multu_done_one_cycle", {63'd0, done}, 64'd0);
    checkOutput("idle_count", {58'd0, count}, 64'd0);

    applyStimulus(MULT, 32'hFFFF_FFFD, 32'd5);
    waitDone(busyCycles, edges);
    checkOutput("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    applyStimulus(MULT, 32'h8000_0000, 32'h8000_0000);
    waitDone(busyCycles, edges);
    checkOutput("mult_minxmin", {hi, lo}, 64'h4000_0000_0000_0000);

    applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2);
    waitDone(busyCycles, edges);
    checkOutput("div_neg7by2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    applyStimulus(DIVU, 32'd100, 32'd7);
    waitDone(busyCycles, edges);
    checkOutput("divu_100by7", {hi, lo}, {32'd2, 32'd14});

    applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(busyCycles, edges);
    checkOutput("div_min_by_m1", {hi, lo}, {32'd0, 32'h8000_0000});
    checkOutput("div_min_by_m1_dbz", {63'd0, divByZero}, 64'd0);

    // Divide by zero short-circuits straight to DONE
    applyStimulus(DIVU, 32'd7, 32'd0);
    waitDone(busyCycles, edges);
    checkOutput("dbz_flag", {63'd0, divByZero}, 64'd1);
    checkOutput("dbz_result", {hi, lo}, {32'd7, 32'hFFFF_FFFF});
    checkOutput("dbz_busy_cycles", 64'(busyCycles), 64'd0);
    checkOutput("dbz_done_edge", 64'(edges), 64'd1);
    checkOutput("dbz_count", {58'd0, count}, 64'd0);

    // Next valid start clears the flag; HI/LO hold through CALC
    applyStimulus(DIVU, 32'd9, 32'd3);
    checkOutput("dbz_cleared", {63'd0, divByZero}, 64'd0);
    waitCount(6'd5);
    checkOutput("hold_during_calc", {hi, lo}, {32'd7, 32'hFFFF_FFFF});
    waitDone(busyCycles, edges);
    checkOutput("divu_9by3", {hi, lo}, {32'd0, 32'd3});

    // Reset mid-operation aborts without commit
    applyStimulus(MULT, 32'd6, 32'd7);
    waitCount(6'd10);
    reset = 1'b0;
    #1;
    checkOutput("abort_hilo", {hi, lo}, 64'd0);
    checkOutput("abort_flags", {61'd0, busy, done, divByZero}, 64'd0);
    checkOutput("abort_count", {58'd0, count}, 64'd0);
    @(negedge Clk);
    reset = 1'b1;
    applyStimulus(DIVU, 32'd9, 32'd3);
    waitDone(busyCycles, edges);
    checkOutput("after_abort_divu", {hi, lo}, {32'd0, 32'd3});

    // Start during CALC is ignored
    applyStimulus(MULTU, 32'd1000, 32'd1000);
    waitCount(6'd5);
    start = 1'b1; op = DIVU; rsVal = 32'd50; rtVal = 32'd5;
    @(posedge Clk);
    #1 start = 1'b0;
    checkOutput("ignored_start_count", {58'd0, count}, 64'd6);
    waitDone(busyCycles, edges);
    checkOutput("ignored_start_result", {hi, lo}, 64'd1000000);

    // Start held during DONE is accepted back-to-back
    start = 1'b1; op = DIVU; rsVal = 32'd100; rtVal = 32'd7;
    @(posedge Clk);
    #1 start = 1'b0;
    checkOutput("b2b_busy", {63'd0, busy}, 64'd1);
    checkOutput("b2b_count", {58'd0, count}, 64'd0);
    waitDone(busyCycles, edges);
    checkOutput("b2b_result", {hi, lo}, {32'd2, 32'd14});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
